// File: rtl/mem_access_ctrl.sv
// Load/store sequencer between the pipeline memory stage and the data cache.
// Captures one request, checks alignment, runs a req/ack handshake with a
// bounded wait, and returns aligned, extended load data.
module mem_access_ctrl #(
  parameter int n       = 32,
  parameter int TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         mem_rd,
  input  logic         mem_wr,
  input  logic [n-1:0] addr,
  input  logic [1:0]   size,
  input  logic         sign_ext,
  input  logic [n-1:0] st_data,
  output logic         cache_req,
  output logic         cache_we,
  output logic [n-1:0] cache_addr,
  output logic [3:0]   cache_be,
  output logic [n-1:0] cache_wdata,
  input  logic         cache_ack,
  input  logic [n-1:0] cache_rdata,
  output logic         ld_str,
  output logic [n-1:0] load_data,
  output logic         stall,
  output logic         done,
  output logic         err
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, ERR} state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t       state, next_state;
  logic [7:0]   wait_cnt;
  logic [n-1:0] addr_q;
  logic [n-1:0] st_data_q;
  logic [1:0]   size_q;
  logic         sign_ext_q;
  logic         is_store_q;
  logic         request;
  logic         req_err;
  logic         active;
  logic [n-1:0] shifted_rdata;
  logic [n-1:0] ext_data;

  assign request = mem_rd | mem_wr;
  assign req_err = (mem_rd & mem_wr)
                 | (size == 2'b11)
                 | ((size == 2'b01) & addr[0])
                 | ((size == 2'b10) & (addr[1:0] != 2'b00));
  assign active  = (state == REQ) || (state == WAIT);

  // State register
  always_ff @(posedge clk) begin
    if (clr) state <= IDLE;
    else     state <= next_state;
  end

  // Wait-cycle counter: 1 on entry to WAIT, counts up while waiting
  always_ff @(posedge clk) begin
    if (clr)                 wait_cnt <= 8'd0;
    else if (state == REQ)   wait_cnt <= 8'd1;
    else if (state == WAIT)  wait_cnt <= wait_cnt + 8'd1;
    else                     wait_cnt <= 8'd0;
  end

  // Capture the request so cache-side outputs stay stable during the access
  always_ff @(posedge clk) begin
    if (clr) begin
      addr_q     <= '0;
      st_data_q  <= '0;
      size_q     <= 2'b00;
      sign_ext_q <= 1'b0;
      is_store_q <= 1'b0;
    end else if (state == IDLE && request) begin
      addr_q     <= addr;
      st_data_q  <= st_data;
      size_q     <= size;
      sign_ext_q <= sign_ext;
      is_store_q <= mem_wr;
    end
  end

  // Next-state logic and handshake/pipeline control outputs
  always_comb begin
    next_state = state;
    cache_req  = 1'b0;
    stall      = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    ld_str     = 1'b0;
    case (state)
      IDLE: begin
        stall = request;
        if (request) next_state = req_err ? ERR : REQ;
      end
      REQ: begin
        cache_req  = 1'b1;
        stall      = 1'b1;
        ld_str     = is_store_q;
        next_state = cache_ack ? DONE : WAIT;
      end
      WAIT: begin
        cache_req = 1'b1;
        stall     = 1'b1;
        ld_str    = is_store_q;
        if (cache_ack)                    next_state = DONE;
        else if (wait_cnt == TIMEOUT_CNT) next_state = ERR;
      end
      DONE: begin
        done       = 1'b1;
        ld_str     = is_store_q;
        next_state = IDLE;
      end
      ERR: begin
        done       = 1'b1;
        err        = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Cache-side address, byte enables, replicated write data and load extension
  always_comb begin
    cache_addr    = {addr_q[n-1:2], 2'b00};
    cache_we      = active & is_store_q;
    cache_be      = 4'b0000;
    cache_wdata   = st_data_q;
    shifted_rdata = cache_rdata >> {addr_q[1:0], 3'b000};
    ext_data      = shifted_rdata;
    case (size_q)
      2'b00: begin
        cache_wdata = {4{st_data_q[7:0]}};
        ext_data    = {{(n-8){sign_ext_q & shifted_rdata[7]}}, shifted_rdata[7:0]};
        if (active && is_store_q) cache_be = 4'b0001 << addr_q[1:0];
      end
      2'b01: begin
        cache_wdata = {2{st_data_q[15:0]}};
        ext_data    = {{(n-16){sign_ext_q & shifted_rdata[15]}}, shifted_rdata[15:0]};
        if (active && is_store_q) cache_be = addr_q[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        if (active && is_store_q) cache_be = 4'b1111;
      end
    endcase
  end

  // Load result register, updated only when a load is acknowledged
  always_ff @(posedge clk) begin
    if (clr)                                  load_data <= '0;
    else if (active && cache_ack && !is_store_q) load_data <= ext_data;
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed vector table, hand-written
// multi-cycle sequences, and randomized transactions against a reference model.
module tb_mem_access_ctrl;

  localparam int TO = 3;

  logic        clk = 1'b0;
  logic        clr;
  logic        mem_rd, mem_wr;
  logic [31:0] addr;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] st_data;
  logic        cache_req, cache_we;
  logic [31:0] cache_addr;
  logic [3:0]  cache_be;
  logic [31:0] cache_wdata;
  logic        cache_ack;
  logic [31:0] cache_rdata;
  logic        ld_str;
  logic [31:0] load_data;
  logic        stall, done, err;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_ld;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] a;
    logic [1:0]  sz;
    logic        sx;
    logic [31:0] st;
    logic [31:0] rdw;
    int          dly;
    logic        e_err;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_load;
  } vec_t;

  vec_t vecs[13];

  mem_access_ctrl #(.n(32), .TIMEOUT(TO)) dut (
    .clk(clk), .clr(clr), .mem_rd(mem_rd), .mem_wr(mem_wr), .addr(addr),
    .size(size), .sign_ext(sign_ext), .st_data(st_data),
    .cache_req(cache_req), .cache_we(cache_we), .cache_addr(cache_addr),
    .cache_be(cache_be), .cache_wdata(cache_wdata), .cache_ack(cache_ack),
    .cache_rdata(cache_rdata), .ld_str(ld_str), .load_data(load_data),
    .stall(stall), .done(done), .err(err)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Safety net in case a sequence never returns
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_output32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: request rejected before any cache access
  function automatic logic model_err(logic rd, logic wr, logic [31:0] a, logic [1:0] sz);
    return (rd && wr) || (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
  endfunction

  function automatic logic [3:0] model_be(logic wr, logic [31:0] a, logic [1:0] sz);
    int lanes;
    if (!wr) return 4'd0;
    lanes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 3 : 15;
    return 4'(lanes << ((sz == 2'd2) ? 0 : a % 4));
  endfunction

  function automatic logic [31:0] model_wdata(logic [31:0] st, logic [1:0] sz);
    if (sz == 2'd0) return (st % 256) * 32'h0101_0101;
    if (sz == 2'd1) return (st % 65536) * 32'h0001_0001;
    return st;
  endfunction

  function automatic logic [31:0] model_load(logic [31:0] rdw, logic [31:0] a, logic [1:0] sz, logic sx);
    logic [31:0] v;
    v = rdw / (32'd1 << (8 * (a % 4)));
    if (sz == 2'd0) begin
      v = v % 256;
      if (sx && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = v % 65536;
      if (sx && v >= 32768) v = v + 32'hFFFF_0000;
    end
    return v;
  endfunction

  // One full transaction: request cycle, cache phase with ack after dly cycles
  // (dly > TO means never), then the completion cycle.
  task automatic apply_stimulus(input logic rd, input logic wr, input logic [31:0] a,
                                input logic [1:0] sz, input logic sx, input logic [31:0] st,
                                input logic [31:0] rdw, input int dly, input logic e_err,
                                input logic [3:0] e_be, input logic [31:0] e_wdata,
                                input logic [31:0] e_load);
    @(negedge clk);
    mem_rd = rd; mem_wr = wr; addr = a; size = sz; sign_ext = sx; st_data = st;
    cache_ack = 1'b0; cache_rdata = $urandom;
    #1;
    check_output1("idle_stall", stall, 1'b1);
    check_output1("idle_req", cache_req, 1'b0);
    @(negedge clk);
    mem_rd = 1'b0; mem_wr = 1'b0;
    addr = $urandom; size = 2'($urandom); sign_ext = 1'($urandom); st_data = $urandom;
    if (e_err) begin
      #1;
      check_output1("err_pulse", err, 1'b1);
      check_output1("err_done", done, 1'b1);
      check_output1("err_no_req", cache_req, 1'b0);
      check_output1("err_stall", stall, 1'b0);
    end else begin
      int k;
      bit acked;
      k = 0;
      acked = 1'b0;
      while (!acked && k <= TO) begin
        cache_ack   = (k == dly);
        cache_rdata = cache_ack ? rdw : $urandom;
        #1;
        check_output1("busy_req", cache_req, 1'b1);
        check_output1("busy_stall", stall, 1'b1);
        check_output1("busy_done", done, 1'b0);
        check_output32("busy_addr", cache_addr, a & 32'hFFFF_FFFC);
        check_output1("busy_we", cache_we, wr);
        check_output32("busy_be", 32'(cache_be), 32'(e_be));
        check_output1("busy_ldstr", ld_str, wr);
        if (wr) check_output32("busy_wdata", cache_wdata, e_wdata);
        acked = cache_ack;
        k++;
        @(negedge clk);
      end
      cache_ack = 1'b0;
      cache_rdata = $urandom;
      #1;
      check_output1("end_done", done, 1'b1);
      check_output1("end_err", err, !acked);
      check_output1("end_stall", stall, 1'b0);
      check_output1("end_req", cache_req, 1'b0);
      if (acked) begin
        check_output1("end_ldstr", ld_str, wr);
        if (!wr) exp_ld = e_load;
      end
      check_output32("load_data", load_data, exp_ld);
    end
    @(negedge clk);
    #1;
    check_output1("after_done", done, 1'b0);
    check_output1("after_stall", stall, 1'b0);
  endtask

  initial begin
    logic        r_rd, r_wr, r_sx;
    logic [31:0] r_a, r_st, r_rdw;
    logic [1:0]  r_sz;
    int          op;

    vecs[0]  = '{1'b1, 1'b0, 32'h0000_1003, 2'd0, 1'b1, 32'h0, 32'h80FF_FF12, 0, 1'b0, 4'b0000, 32'h0, 32'hFFFF_FF80};
    vecs[1]  = '{1'b0, 1'b1, 32'h0000_2002, 2'd1, 1'b0, 32'h0000_BEEF, 32'h0, 1, 1'b0, 4'b1100, 32'hBEEF_BEEF, 32'h0};
    vecs[2]  = '{1'b1, 1'b0, 32'h0000_3001, 2'd2, 1'b0, 32'h0, 32'h0, 0, 1'b1, 4'b0000, 32'h0, 32'h0};
    vecs[3]  = '{1'b1, 1'b0, 32'h0000_4000, 2'd2, 1'b0, 32'h0, 32'h1111_2222, 9, 1'b0, 4'b0000, 32'h0, 32'h0};
    vecs[4]  = '{1'b1, 1'b0, 32'h0000_4004, 2'd2, 1'b0, 32'h0, 32'hCAFE_F00D, 3, 1'b0, 4'b0000, 32'h0, 32'hCAFE_F00D};
    vecs[5]  = '{1'b1, 1'b0, 32'h0000_5002, 2'd1, 1'b0, 32'h0, 32'h9ABC_1234, 2, 1'b0, 4'b0000, 32'h0, 32'h0000_9ABC};
    vecs[6]  = '{1'b1, 1'b0, 32'h0000_5000, 2'd1, 1'b1, 32'h0, 32'h0001_8001, 0, 1'b0, 4'b0000, 32'h0, 32'hFFFF_8001};
    vecs[7]  = '{1'b0, 1'b1, 32'h0000_6001, 2'd0, 1'b0, 32'h1234_56A5, 32'h0, 0, 1'b0, 4'b0010, 32'hA5A5_A5A5, 32'h0};
    vecs[8]  = '{1'b0, 1'b1, 32'h0000_7000, 2'd2, 1'b0, 32'hDEAD_BEEF, 32'h0, 2, 1'b0, 4'b1111, 32'hDEAD_BEEF, 32'h0};
    vecs[9]  = '{1'b1, 1'b1, 32'h0000_7000, 2'd2, 1'b0, 32'h0, 32'h0, 0, 1'b1, 4'b0000, 32'h0, 32'h0};
    vecs[10] = '{1'b1, 1'b0, 32'h0000_7000, 2'd3, 1'b0, 32'h0, 32'h0, 0, 1'b1, 4'b0000, 32'h0, 32'h0};
    vecs[11] = '{1'b0, 1'b1, 32'h0000_0001, 2'd1, 1'b0, 32'h0, 32'h0, 0, 1'b1, 4'b0000, 32'h0, 32'h0};
    vecs[12] = '{1'b1, 1'b0, 32'h0000_0002, 2'd0, 1'b0, 32'h0, 32'h00F0_0000, 1, 1'b0, 4'b0000, 32'h0, 32'h0000_00F0};

    clr = 1'b1; mem_rd = 1'b0; mem_wr = 1'b0; addr = '0; size = 2'd0;
    sign_ext = 1'b0; st_data = '0; cache_ack = 1'b0; cache_rdata = '0;
    exp_ld = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    check_output1("rst_req", cache_req, 1'b0);
    check_output1("rst_we", cache_we, 1'b0);
    check_output32("rst_be", 32'(cache_be), 32'h0);
    check_output1("rst_done", done, 1'b0);
    check_output1("rst_err", err, 1'b0);
    check_output1("rst_ldstr", ld_str, 1'b0);
    check_output32("rst_load", load_data, 32'h0);
    check_output1("rst_stall", stall, 1'b0);
    clr = 1'b0;

    // Directed vector table
    for (int i = 0; i < 13; i++)
      apply_stimulus(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].sz, vecs[i].sx, vecs[i].st,
                     vecs[i].rdw, vecs[i].dly, vecs[i].e_err, vecs[i].e_be,
                     vecs[i].e_wdata, vecs[i].e_load);

    // Reset while waiting on the cache aborts without a completion pulse
    @(negedge clk);
    mem_rd = 1'b1; addr = 32'h0000_8000; size = 2'd2; cache_ack = 1'b0;
    #1 check_output1("clr_seq_stall", stall, 1'b1);
    @(negedge clk);
    mem_rd = 1'b0;
    #1 check_output1("clr_seq_req", cache_req, 1'b1);
    @(negedge clk);
    #1 check_output1("clr_seq_wait", cache_req, 1'b1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    #1;
    check_output1("clr_abort_req", cache_req, 1'b0);
    check_output1("clr_abort_stall", stall, 1'b0);
    check_output1("clr_abort_done", done, 1'b0);
    check_output32("clr_abort_load", load_data, 32'h0);
    exp_ld = 32'h0;
    @(negedge clk);
    #1 check_output1("clr_no_done", done, 1'b0);
    apply_stimulus(1'b1, 1'b0, 32'h0000_8004, 2'd2, 1'b0, 32'h0, 32'h0BAD_CAFE, 1,
                   1'b0, 4'b0000, 32'h0, 32'h0BAD_CAFE);

    // Back-to-back loads with mem_rd held: IDLE, REQ, DONE, IDLE, REQ, DONE
    begin
      logic exp_stall[6];
      logic exp_req[6];
      logic exp_done[6];
      exp_stall = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      exp_req   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      exp_done  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        mem_rd = (c < 5); addr = 32'h0000_0040; size = 2'd2;
        cache_ack = 1'b1; cache_rdata = 32'h1234_5678;
        #1;
        check_output1("b2b_stall", stall, exp_stall[c]);
        check_output1("b2b_req", cache_req, exp_req[c]);
        check_output1("b2b_done", done, exp_done[c]);
      end
      cache_ack = 1'b0;
      mem_rd = 1'b0;
      exp_ld = 32'h1234_5678;
      check_output32("b2b_load", load_data, exp_ld);
    end

    // Randomized transactions against the reference model
    for (int t = 0; t < 60; t++) begin
      op = $urandom_range(0, 9);
      r_rd = (op <= 5);
      r_wr = (op == 0) || (op >= 6);
      r_sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      r_a  = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (r_sz == 2'd1) r_a = r_a & 32'hFFFF_FFFE;
        if (r_sz == 2'd2) r_a = r_a & 32'hFFFF_FFFC;
      end
      r_sx  = 1'($urandom);
      r_st  = $urandom;
      r_rdw = $urandom;
      apply_stimulus(r_rd, r_wr, r_a, r_sz, r_sx, r_st, r_rdw, $urandom_range(0, TO + 2),
                     model_err(r_rd, r_wr, r_a, r_sz), model_be(r_wr, r_a, r_sz),
                     model_wdata(r_st, r_sz), model_load(r_rdw, r_a, r_sz, r_sx));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
